// File: rtl/adder_pipe_pkg.sv
// rtl/adder_pipe_pkg.sv - shared stage flags and width helper for adder_pipe
package adder_pipe_pkg;

  typedef struct packed {
    logic acc;
    logic last;
  } beat_flags_t;

  function automatic int sum_width(input int data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// rtl/adder_pipe_slice.sv - one enable-gated pipeline register carrying valid plus payload
module adder_pipe_slice
  import adder_pipe_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined pair adder with grouped accumulation; ADDER_SATURATE_EN clamps the accumulator
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in1,
  input  logic [DATA_WIDTH-1:0] in2,
  input  logic                  in_acc,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out,
  output logic                  out_ovf
);

  localparam int SUM_WIDTH = sum_width(DATA_WIDTH);
  localparam int ACC_EXT   = ACC_WIDTH + 1;

  typedef struct packed {
    logic [SUM_WIDTH-1:0] sum;
    beat_flags_t          flags;
  } payload_t;

  localparam int PW = $bits(payload_t);

  logic                 out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0] out_q, out_d;
  logic                 out_ovf_q, out_ovf_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;

  // One global enable: the whole pipe, accumulator included, freezes on a stall.
  logic en;
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  logic [STAGES-1:0]         stg_valid;
  logic [STAGES-1:0][PW-1:0] stg_data;
  payload_t                  s1_payload;

  assign s1_payload   = {SUM_WIDTH'(in1) + SUM_WIDTH'(in2), in_acc, in_last};
  assign stg_valid[0] = in_valid && en;
  assign stg_data[0]  = s1_payload;

  for (genvar i = 0; i < STAGES - 1; i++) begin : g_slice
    adder_pipe_slice #(.W(PW)) u_slice (
      .clk    (clk),
      .rst_n  (rst),
      .en_i   (en),
      .valid_i(stg_valid[i]),
      .data_i (stg_data[i]),
      .valid_o(stg_valid[i+1]),
      .data_o (stg_data[i+1])
    );
  end

  logic     fin_valid;
  payload_t fin;
  assign fin_valid = stg_valid[STAGES-1];
  assign fin       = stg_data[STAGES-1];

  logic [ACC_EXT-1:0]   acc_sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] acc_next;

  assign acc_sum = ACC_EXT'(acc_q) + ACC_EXT'(fin.sum);
  assign carry   = acc_sum[ACC_WIDTH];

`ifdef ADDER_SATURATE_EN
  assign acc_next = carry ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
  assign acc_next = acc_sum[ACC_WIDTH-1:0];
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (fin_valid && !fin.flags.acc) begin
        out_valid_d = 1'b1;
        out_d       = ACC_WIDTH'(fin.sum);
        out_ovf_d   = 1'b0;
      end else if (fin_valid && fin.flags.last) begin
        out_valid_d = 1'b1;
        out_d       = acc_next;
        out_ovf_d   = sticky_q | carry;
        acc_d       = '0;
        sticky_d    = 1'b0;
      end else if (fin_valid) begin
        acc_d       = acc_next;
        sticky_d    = sticky_q | carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe at STAGES 2, 1 and 4 (honours ADDER_SATURATE_EN)
module tb_adder_pipe;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [15:0] val;
    logic        ovf;
    logic [31:0] acyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_acc, in_last;
  logic [7:0]  in1, in2;
  logic        rdy0;
  logic [2:0]  irdy, ovld, oovf, ordy;
  logic [15:0] o0, o1, o2;
  logic [15:0] oval [NDUT];

  assign ordy    = {1'b1, 1'b1, rdy0};
  assign oval[0] = o0;
  assign oval[1] = o1;
  assign oval[2] = o2;

  adder_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]), .in1(in1), .in2(in2),
    .in_acc(in_acc), .in_last(in_last), .out_valid(ovld[0]), .out_ready(ordy[0]),
    .out(o0), .out_ovf(oovf[0]));

  adder_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]), .in1(in1), .in2(in2),
    .in_acc(in_acc), .in_last(in_last), .out_valid(ovld[1]), .out_ready(ordy[1]),
    .out(o1), .out_ovf(oovf[1]));

  adder_pipe #(.DATA_WIDTH(8), .ACC_WIDTH(16), .STAGES(4)) dut_s4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[2]), .in1(in1), .in2(in2),
    .in_acc(in_acc), .in_last(in_last), .out_valid(ovld[2]), .out_ready(ordy[2]),
    .out(o2), .out_ovf(oovf[2]));

  always #5 clk = ~clk;

  logic [31:0] cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] macc   [NDUT];
  logic        mst    [NDUT];
  logic        prev_v [NDUT];
  logic        prev_x [NDUT];
  exp_t        exp_q  [NDUT][$];
  logic [16:0] got_q  [$];

  function automatic int stg(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic model_accept(input int k);
    logic [31:0] s, t;
    logic        c;
    s = 32'(in1) + 32'(in2);
    if (!in_acc) begin
      exp_q[k].push_back({s[15:0], 1'b0, cyc});
    end else begin
      t = macc[k] + s;
      c = (t > 32'd65535);
`ifdef ADDER_SATURATE_EN
      if (c) t = 32'd65535;
`else
      t = t % 32'd65536;
`endif
      if (in_last) begin
        exp_q[k].push_back({t[15:0], mst[k] | c, cyc});
        macc[k] = 0;
        mst[k]  = 1'b0;
      end else begin
        macc[k] = t;
        mst[k]  = mst[k] | c;
      end
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    int   want_lat;
    if (!rst) begin
      for (int k = 0; k < NDUT; k++) begin
        macc[k]   = 0;
        mst[k]    = 1'b0;
        prev_v[k] = 1'b0;
        prev_x[k] = 1'b0;
        exp_q[k].delete();
      end
    end else begin
      for (int k = 0; k < NDUT; k++) begin
        if (ovld[k]) begin
          if (exp_q[k].size() == 0) begin
            chk($sformatf("unexpected_out[s%0d] value", stg(k)), 32'(oval[k]), 32'hFFFF_FFFF);
          end else begin
            e = exp_q[k][0];
            chk($sformatf("out[s%0d]", stg(k)), {15'd0, oovf[k], oval[k]}, {15'd0, e.ovf, e.val});
            if (!prev_v[k] || prev_x[k]) begin
              lat      = int'(cyc - e.acyc);
              want_lat = (k == 0 && lat > stg(k)) ? lat : stg(k);
              chk($sformatf("latency[s%0d]", stg(k)), lat, want_lat);
            end
            if (ordy[k]) void'(exp_q[k].pop_front());
          end
          if (k == 0 && ordy[0]) got_q.push_back({oovf[0], oval[0]});
        end
        chk($sformatf("in_ready[s%0d]", stg(k)), 32'(irdy[k]), 32'(!ovld[k] || ordy[k]));
        if (in_valid && irdy[k]) model_accept(k);
        prev_v[k] = ovld[k];
        prev_x[k] = ovld[k] && ordy[k];
      end
    end
  end

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = irdy[0];
      @(posedge clk);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic acc, input logic last);
    in1 = a; in2 = b; in_acc = acc; in_last = last; in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic expect_lit(input string name, input logic [15:0] val, input logic ovf);
    logic [16:0] g;
    for (int i = 0; i < 40 && got_q.size() == 0; i++) @(negedge clk);
    if (got_q.size() == 0) begin
      chk({name, "_timeout"}, 0, 1);
    end else begin
      g = got_q.pop_front();
      chk(name, 32'(g), {15'd0, ovf, val});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0;
    in1 = 8'd0; in2 = 8'd0; rdy0 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_out_valid", 32'(ovld[k]), 0);
      chk("reset_out", 32'(oval[k]), 0);
      chk("reset_out_ovf", 32'(oovf[k]), 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", 32'(irdy), 32'd7);

    send(8'd5, 8'd2, 1'b0, 1'b0);
    chk("t1_not_yet_valid", 32'(ovld[0]), 0);
    send(8'd255, 8'd255, 1'b0, 1'b0);
    chk("t1_first_valid", 32'(ovld[0]), 1);
    chk("t1_first_out", 32'(o0), 7);
    @(posedge clk);
    #1;
    chk("t1_second_out", {15'd0, oovf[0], o0}, 510);
    expect_lit("t1_res0", 16'd7, 1'b0);
    expect_lit("t1_res1", 16'd510, 1'b0);

    send(8'd1, 8'd2, 1'b1, 1'b0);
    send(8'd3, 8'd4, 1'b1, 1'b0);
    send(8'd5, 8'd6, 1'b1, 1'b1);
    expect_lit("t2_group", 16'd21, 1'b0);
    send(8'd10, 8'd0, 1'b1, 1'b1);
    expect_lit("t2_cleared", 16'd10, 1'b0);

    rdy0 = 1'b0;
    send(8'd1, 8'd1, 1'b0, 1'b0);
    send(8'd2, 8'd2, 1'b0, 1'b0);
    in1 = 8'd3; in2 = 8'd3; in_acc = 1'b0; in_last = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall_in_ready", 32'(irdy[0]), 0);
      chk("t3_stall_out", {15'd0, ovld[0], o0}, 32'h1_0002);
      @(posedge clk);
      #1;
    end
    rdy0 = 1'b1;
    wait_accept();
    expect_lit("t3_res0", 16'd2, 1'b0);
    expect_lit("t3_res1", 16'd4, 1'b0);
    expect_lit("t3_res2", 16'd6, 1'b0);

    for (int i = 1; i <= 129; i++) send(8'd255, 8'd255, 1'b1, 1'(i == 129));
`ifdef ADDER_SATURATE_EN
    expect_lit("t4_overflow", 16'd65535, 1'b1);
`else
    expect_lit("t4_overflow", 16'd254, 1'b1);
`endif
    send(8'd1, 8'd0, 1'b1, 1'b1);
    expect_lit("t4_after", 16'd1, 1'b0);

    send(8'd100, 8'd0, 1'b1, 1'b0);
    send(8'd100, 8'd0, 1'b1, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'd1, 8'd1, 1'b1, 1'b1);
    expect_lit("t5_after_reset", 16'd2, 1'b0);

    send(8'd4, 8'd4, 1'b1, 1'b0);
    send(8'd1, 8'd1, 1'b0, 1'b0);
    send(8'd2, 8'd0, 1'b1, 1'b1);
    expect_lit("t6_plain", 16'd2, 1'b0);
    expect_lit("t6_group", 16'd10, 1'b0);

    repeat (10) @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) chk($sformatf("drained[s%0d]", stg(k)), exp_q[k].size(), 0);
    chk("unclaimed_results", got_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined successor to the single-pair registered adder. It adds two unsigned operands per beat under valid/ready flow control. Beats can be emitted individually (plain mode) or summed into an accumulator that emits once per group (accumulate mode). It sits between a producer stream and a consumer stream in the NoC peripheral datapath, with overflow reporting and optional saturation.

## Interface
Parameters:
- DATA_WIDTH, 8, operand width; must be ≥ 1.
- ACC_WIDTH, 16, result/accumulator width; must be ≥ DATA_WIDTH+1.
- STAGES, 2, beat-to-output latency in cycles; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the beat this cycle.
- in1  in  DATA_WIDTH  operand A, unsigned.
- in2  in  DATA_WIDTH  operand B, unsigned.
- in_acc  in  1  0 = plain beat, 1 = accumulate beat.
- in_last  in  1  closes an accumulate group; ignored when in_acc=0.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out  out  ACC_WIDTH  result.
- out_ovf  out  1  result overflowed ACC_WIDTH.

## Operation
- A beat is accepted when in_valid && in_ready.
- Stage 1 forms the pair sum, zero-extended to DATA_WIDTH+1 bits. Stages 2..STAGES-1 are pure delay. The final stage holds the accumulator register and the output register.
- Plain beat (in_acc=0):
  - out = pair sum zero-extended to ACC_WIDTH, out_ovf=0.
  - The accumulator is untouched.
- Accumulate beat, in_last=0:
  - acc ← acc + pair sum, computed in ACC_WIDTH+1 bits.
  - A carry sets the sticky group-overflow flag.
  - No output is produced; the beat is absorbed.
- Accumulate beat, in_last=1:
  - out = acc + pair sum; out_ovf = sticky flag OR carry of this add.
  - The accumulator and the sticky flag clear to 0 in the same cycle.
- Overflow arithmetic: the accumulator wraps modulo 2^ACC_WIDTH (see Configuration for saturation).
- Plain beats may be interleaved inside an accumulate group. They pass through and leave the group state intact.
- Outputs appear in acceptance order.
- Reset values: out_valid=0, out=0, out_ovf=0, all stage valids=0, acc=0, sticky flag=0. in_ready=1 from the first cycle after reset release.
- Reset asserted mid-group discards the partial sum and all in-flight beats.

## Timing
- Global pipeline enable: en = !out_valid || out_ready; in_ready = en. in_ready is combinational from out_ready and out_valid.
- Latency: a beat accepted at edge N presents its result with out_valid=1 after edge N+STAGES-1. With STAGES=1, the result is registered directly at acceptance.
- Full throughput: one beat per cycle while out_ready=1.
- Stall: when out_valid && !out_ready:
  - every stage holds, including the accumulator;
  - out and out_ovf stay stable;
  - in_ready=0.
- Absorbed (non-last accumulate) beats update the accumulator only on an enabled cycle.
- An output transfer (out_valid && out_ready) and a new final-stage load may occur in the same cycle.
- out_valid drops the cycle after a transfer when no result follows.

## Configuration
- ADDER_SATURATE_EN defined:
  - any accumulate add whose true result exceeds 2^ACC_WIDTH-1 clamps the accumulator to 2^ACC_WIDTH-1;
  - the accumulator holds at that value for the rest of the group;
  - out_ovf is still reported.
- ADDER_SATURATE_EN undefined: modulo wrap as described in Operation.
- Plain mode cannot overflow and is identical in both builds.

## Structure
- Package adder_pipe_pkg:
  - stage payload struct: sum, acc flag, last flag;
  - localparam SUM_WIDTH = DATA_WIDTH+1 (provided as a parametrised function or derived in the module).
- Sub-module adder_pipe_slice: one enable-gated register stage carrying valid plus payload, with async active-low reset. It is instantiated STAGES-1 times via generate.
- The top holds the stage-1 adder, the final accumulate stage, and the handshake logic.

## Test plan
Default parameters (DATA_WIDTH=8, ACC_WIDTH=16, STAGES=2) unless stated.
1. Release reset; plain beats (5,2) then (255,255) with out_ready=1:
   - results 7 then 510, each 1 cycle after acceptance;
   - out_ovf=0;
   - in_ready=1 throughout.
2. Accumulate (1,2), (3,4), then (5,6, last) -> a single output of 21. Next, group (10,0, last) -> 10, confirming the accumulator cleared.
3. Hold out_ready=0 and offer plain beats 1+1, 2+2, 3+3:
   - in_ready falls once out_valid=1;
   - out holds 2 for the whole stall;
   - on release, outputs are 2, 4, 6 in order with none lost.
4. Accumulate 129 beats of (255,255), last on beat 129:
   - without ADDER_SATURATE_EN: out=254, out_ovf=1;
   - with ADDER_SATURATE_EN: out=65535, out_ovf=1;
   - a following group (1,0, last) gives out=1, out_ovf=0.
5. Accumulate (100,0) twice, pulse rst low for 1 cycle, then (1,1, last) -> out=2, out_ovf=0. No stale output appears after reset.
6. Interleave: accumulate (4,4), plain (1,1), accumulate (2,0, last) -> outputs 2 then 10. Repeat with STAGES=1 and STAGES=4 and check the latency changes accordingly.
